// File: rtl/gpio_ctl_if.sv
// CPU data bus seen by the GPIO block: address, write strobe/data in, registered read data out.
// The master drives the address and write signals; the slave returns read data one cycle later.
interface gpio_ctl_if;
  logic [15:0] di;
  logic        we;
  logic [15:0] a;
  logic [15:0] wr_dat;

  modport master (input di, output we, output a, output wr_dat);
  modport slave  (output di, input we, input a, input wr_dat);
endinterface

// File: rtl/gpio_ctl.sv
// Memory-mapped GPIO: LED register, synchronised switches, debounced buttons with sticky W1C events and IRQ.
// Reads return data one cycle after the address is presented; writes act on the strobe edge; never stalls.
module gpio_ctl #(
  parameter int unsigned LED_W           = 8,
  parameter int unsigned SW_W            = 8,
  parameter int unsigned BTN_W           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter logic [13:0] ADDR_LED        = 14'h0000,
  parameter logic [13:0] ADDR_SW         = 14'h0002,
  parameter logic [13:0] ADDR_BTN        = 14'h0004,
  parameter logic [13:0] ADDR_EVT        = 14'h0006,
  parameter logic [13:0] ADDR_IEN        = 14'h0008,
  parameter logic [13:0] ADDR_LED_TGL    = 14'h000A
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  gpio_ctl_if.slave        bus,
  output logic [LED_W-1:0] led,
  input  logic [SW_W-1:0]  sw,
  input  logic [BTN_W-1:0] btn,
  output logic             irq
);

  logic [13:0]      addr;
  logic [SW_W-1:0]  sw_m, sw_s;
  logic [BTN_W-1:0] btn_m, btn_s, stable, evt, ien;
  logic [BTN_W-1:0] accept, rise, evt_clr;
  logic [CNT_W-1:0] cnt [BTN_W];
  logic [15:0]      rd_dat;
  logic             wr_led, wr_tgl, wr_ien, wr_evt;
  logic             unused_bits;

  assign addr        = bus.a[13:0];
  assign unused_bits = ^{bus.a[15:14], bus.wr_dat};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sw_m  <= '0;
      sw_s  <= '0;
      btn_m <= '0;
      btn_s <= '0;
    end else begin
      sw_m  <= sw;
      sw_s  <= sw_m;
      btn_m <= btn;
      btn_s <= btn_m;
    end
  end

  // A button's new level is accepted on the cycle its run of differing samples reaches DEBOUNCE_CYCLES.
  always_comb begin
    accept = '0;
    for (int i = 0; i < BTN_W; i++)
      accept[i] = (btn_s[i] != stable[i]) && (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
  end

  assign rise = accept & btn_s;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stable <= '0;
      for (int i = 0; i < BTN_W; i++)
        cnt[i] <= '0;
    end else begin
      stable <= stable ^ accept;
      for (int i = 0; i < BTN_W; i++) begin
        if ((btn_s[i] == stable[i]) || accept[i])
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  assign wr_led  = bus.we && (addr == ADDR_LED);
  assign wr_tgl  = bus.we && (addr == ADDR_LED_TGL);
  assign wr_ien  = bus.we && (addr == ADDR_IEN);
  assign wr_evt  = bus.we && (addr == ADDR_EVT);
  assign evt_clr = wr_evt ? bus.wr_dat[BTN_W-1:0] : '0;

  // Event set is ORed in after the clear so a same-cycle W1C cannot lose a fresh edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      led <= '0;
      ien <= '0;
      evt <= '0;
      irq <= 1'b0;
    end else begin
      if (wr_led)
        led <= bus.wr_dat[LED_W-1:0];
      else if (wr_tgl)
        led <= led ^ bus.wr_dat[LED_W-1:0];
      if (wr_ien)
        ien <= bus.wr_dat[BTN_W-1:0];
      evt <= (evt & ~evt_clr) | rise;
      irq <= |(evt & ien);
    end
  end

  always_comb begin
    rd_dat = '0;
    case (addr)
      ADDR_LED: rd_dat[LED_W-1:0] = led;
      ADDR_SW:  rd_dat[SW_W-1:0]  = sw_s;
      ADDR_BTN: rd_dat[BTN_W-1:0] = stable;
      ADDR_EVT: rd_dat[BTN_W-1:0] = evt;
      ADDR_IEN: rd_dat[BTN_W-1:0] = ien;
      default:  rd_dat = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      bus.di <= '0;
    else
      bus.di <= rd_dat;
  end

endmodule

// File: tb/tb_gpio_ctl.sv
// Bench for gpio_ctl: directed plus random bus/pin stimulus, expected outputs queued by a reference model.
module tb_gpio_ctl;
  localparam int D     = 4;
  localparam int LED_N = 8;
  localparam int SW_N  = 8;
  localparam int BTN_N = 4;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic [LED_N-1:0] led;
  logic [SW_N-1:0]  sw  = '0;
  logic [BTN_N-1:0] btn = '0;
  logic             irq;
  logic [SW_N-1:0]  want_sw  = '0;
  logic [BTN_N-1:0] want_btn = '0;

  gpio_ctl_if bus_if ();

  gpio_ctl #(.DEBOUNCE_CYCLES(D)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus_if.slave),
    .led     (led),
    .sw      (sw),
    .btn     (btn),
    .irq     (irq)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [15:0] di;
    logic [15:0] led;
    logic [15:0] irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state: values the DUT should hold after the most recent edge.
  logic [LED_N-1:0] m_led;
  logic [BTN_N-1:0] m_ien, m_evt, m_stable, m_btn_m, m_btn_s;
  logic [SW_N-1:0]  m_sw_m, m_sw_s;
  logic             m_irq;
  int               run_start [BTN_N];
  int               cyc = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic model_step();
    exp_t             e;
    logic [15:0]      rd;
    logic [BTN_N-1:0] clr, nstable, rise;
    logic [15:0]      d;
    d = bus_if.wr_dat;
    if (sys_rst) begin
      m_led = '0; m_ien = '0; m_evt = '0; m_stable = '0; m_irq = 1'b0;
      m_btn_m = '0; m_btn_s = '0; m_sw_m = '0; m_sw_s = '0;
      for (int i = 0; i < BTN_N; i++) run_start[i] = -1;
      rd = '0;
    end else begin
      case (bus_if.a[13:0])
        14'h0000: rd = {8'h00, m_led};
        14'h0002: rd = {8'h00, m_sw_s};
        14'h0004: rd = {12'h000, m_stable};
        14'h0006: rd = {12'h000, m_evt};
        14'h0008: rd = {12'h000, m_ien};
        default:  rd = 16'h0000;
      endcase
      // Accept a level once it has differed from the stable level on D consecutive cycles.
      nstable = m_stable;
      rise    = '0;
      for (int i = 0; i < BTN_N; i++) begin
        if (m_btn_s[i] == m_stable[i]) begin
          run_start[i] = -1;
        end else begin
          if (run_start[i] < 0) run_start[i] = cyc;
          if (cyc - run_start[i] + 1 == D) begin
            nstable[i]   = m_btn_s[i];
            rise[i]      = m_btn_s[i];
            run_start[i] = -1;
          end
        end
      end
      m_irq = |(m_evt & m_ien);
      clr   = '0;
      if (bus_if.we) begin
        case (bus_if.a[13:0])
          14'h0000: m_led = d[7:0];
          14'h000A: m_led = m_led ^ d[7:0];
          14'h0008: m_ien = d[3:0];
          14'h0006: clr   = d[3:0];
          default:  ;
        endcase
      end
      m_evt    = (m_evt & ~clr) | rise;
      m_stable = nstable;
      m_sw_s   = m_sw_m;  m_sw_m  = sw;
      m_btn_s  = m_btn_m; m_btn_m = btn;
    end
    cyc++;
    e.di  = rd;
    e.led = {8'h00, m_led};
    e.irq = {15'h0000, m_irq};
    exp_q.push_back(e);
  endtask

  task automatic step(input logic rst, input logic we, input logic [15:0] a, input logic [15:0] d);
    @(negedge sys_clk);
    sys_rst       = rst;
    bus_if.we     = we;
    bus_if.a      = a;
    bus_if.wr_dat = d;
    sw            = want_sw;
    btn           = want_btn;
    model_step();
  endtask

  task automatic rd(input logic [15:0] a);
    step(1'b0, 1'b0, a, 16'h0000);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    step(1'b0, 1'b1, a, d);
  endtask

  always @(posedge sys_clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("di",  bus_if.di, e.di);
      chk("led", {8'h00, led}, e.led);
      chk("irq", {15'h0000, irq}, e.irq);
    end
  end

  initial begin
    logic [15:0] addr_tbl [7];
    bus_if.we     = 1'b0;
    bus_if.a      = '0;
    bus_if.wr_dat = '0;
    addr_tbl[0] = 16'h0000; addr_tbl[1] = 16'h0002; addr_tbl[2] = 16'h0004;
    addr_tbl[3] = 16'h0006; addr_tbl[4] = 16'h0008; addr_tbl[5] = 16'h000A;
    addr_tbl[6] = 16'h0010;

    step(1'b1, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 5; i++) rd(addr_tbl[i]);

    wr(16'h0000, 16'h00A5);
    wr(16'h000A, 16'h000F);
    rd(16'h0000);
    rd(16'h000A);
    wr(16'h0000, 16'h0011);
    rd(16'h0000);

    want_sw = 8'h3C;
    repeat (4) rd(16'h0002);
    rd(16'h0010);
    rd(16'hC002);

    want_btn = 4'b0010;
    repeat (3) rd(16'h0004);
    want_btn = 4'b0000;
    repeat (8) rd(16'h0006);

    want_btn = 4'b0010;
    repeat (8) rd(16'h0004);
    rd(16'h0006);
    want_btn = 4'b0000;
    repeat (8) rd(16'h0004);
    rd(16'h0006);

    wr(16'h0008, 16'h0002);
    rd(16'h0000);
    rd(16'h0000);
    wr(16'h0006, 16'h0002);
    rd(16'h0006);
    rd(16'h0000);

    want_btn = 4'b0010;
    repeat (8) rd(16'h0006);
    wr(16'h0008, 16'h0000);
    rd(16'h0008);
    rd(16'h0008);
    want_btn = 4'b0000;
    repeat (8) rd(16'h0004);

    // Clear of evt[0] lands on the same edge that accepts btn[0].
    want_btn = 4'b0001;
    repeat (5) rd(16'h0006);
    wr(16'h0006, 16'h0001);
    rd(16'h0006);
    rd(16'h0006);

    wr(16'h0000, 16'h005A);
    wr(16'h0008, 16'h000F);
    want_btn = 4'b0101;
    repeat (3) rd(16'h0004);
    step(1'b1, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b0, 16'h0, 16'h0);
    repeat (10) rd(16'h0006);
    wr(16'h0008, 16'h000F);
    rd(16'h0004);

    for (int n = 0; n < 800; n++) begin
      logic [15:0] a;
      logic        rst_r;
      if ($urandom_range(0, 15) == 0) want_sw = SW_N'($urandom);
      for (int b = 0; b < BTN_N; b++)
        if ($urandom_range(0, 9) == 0) want_btn[b] = ~want_btn[b];
      a     = ($urandom_range(0, 7) == 0) ? 16'($urandom) : addr_tbl[$urandom_range(0, 6)];
      rst_r = ($urandom_range(0, 299) == 0);
      step(rst_r, ($urandom_range(0, 2) == 0), a, 16'($urandom));
    end

    rd(16'h0000);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge sys_clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
